// File: rtl/gdp_datapath.sv
// gdp_datapath: datapath for the general-purpose datapath (GDP).
// It executes one control word per clock from the GDP control unit:
// input mux -> 4-entry register file -> ALU -> shifter -> output gate.
// nEqZero is combinational so the control unit can branch on the value
// being written in the same cycle.
module gdp_datapath #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             IE,
    input  logic             WE,
    input  logic [1:0]       WA,
    input  logic             RAE,
    input  logic [1:0]       RAA,
    input  logic             RBE,
    input  logic [1:0]       RBA,
    input  logic [2:0]       ALU,
    input  logic [1:0]       SH,
    input  logic             OE,
    input  logic [WIDTH-1:0] din,
    output logic             nEqZero,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] rf_q [0:3];
    logic [WIDTH-1:0] rf_d [0:3];
    logic [WIDTH-1:0] a_val;
    logic [WIDTH-1:0] b_val;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] sh_res;
    logic [WIDTH-1:0] mux_val;

    // Combinational read ports; a disabled port reads as zero.
    always_comb begin
        a_val = '0;
        b_val = '0;
        if (RAE) a_val = rf_q[RAA];
        if (RBE) b_val = rf_q[RBA];
    end

    // ALU: every code is defined, arithmetic wraps modulo 2^WIDTH.
    always_comb begin
        alu_res = a_val;
        unique case (ALU)
            3'b000: alu_res = a_val;
            3'b001: alu_res = a_val & b_val;
            3'b010: alu_res = a_val | b_val;
            3'b011: alu_res = ~a_val;
            3'b100: alu_res = a_val + b_val;
            3'b101: alu_res = a_val - b_val;
            3'b110: alu_res = a_val + WIDTH'(1);
            3'b111: alu_res = a_val - WIDTH'(1);
            default: alu_res = a_val;
        endcase
    end

    // Shifter on the ALU result: pass, shl, shr (zero fill), rotate right.
    always_comb begin
        sh_res = alu_res;
        unique case (SH)
            2'b00: sh_res = alu_res;
            2'b01: sh_res = {alu_res[WIDTH-2:0], 1'b0};
            2'b10: sh_res = {1'b0, alu_res[WIDTH-1:1]};
            2'b11: sh_res = {alu_res[0], alu_res[WIDTH-1:1]};
            default: sh_res = alu_res;
        endcase
    end

    // Input mux, zero flag and gated output; no holding register on dout.
    always_comb begin
        mux_val = IE ? din : sh_res;
        nEqZero = (mux_val == '0);
        dout    = OE ? sh_res : '0;
    end

    // Next register-file contents: only the addressed entry changes on a write.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            rf_d[i] = rf_q[i];
        end
        if (WE) begin
            rf_d[WA] = mux_val;
        end
    end

    // Register file; reset clears every entry without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                rf_q[i] <= rf_d[i];
            end
        end
    end

endmodule

// File: tb/tb_gdp_datapath.sv
// Testbench for gdp_datapath: table of control words with expected
// dout/nEqZero pushed to a scoreboard queue, plus hand-written reset and
// summation sequences.
module tb_gdp_datapath;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ie, we, rae, rbe, oe;
    logic [1:0] wa, raa, rba, sh;
    logic [2:0] alu;
    logic [7:0] din;
    logic       nez;
    logic [7:0] dout;

    gdp_datapath #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .IE(ie), .WE(we), .WA(wa),
        .RAE(rae), .RAA(raa), .RBE(rbe), .RBA(rba), .ALU(alu), .SH(sh),
        .OE(oe), .din(din), .nEqZero(nez), .dout(dout)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       ie, we;
        logic [1:0] wa;
        logic       rae;
        logic [1:0] raa;
        logic       rbe;
        logic [1:0] rba;
        logic [2:0] alu;
        logic [1:0] sh;
        logic       oe;
        logic [7:0] din;
        logic [7:0] e_dout;
        logic       e_z;
    } vec_t;

    typedef struct {
        string      name;
        logic [7:0] dout;
        logic       z;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t mk(input string nm, input logic ie_, input logic we_,
                                input logic [1:0] wa_, input logic rae_, input logic [1:0] raa_,
                                input logic rbe_, input logic [1:0] rba_, input logic [2:0] alu_,
                                input logic [1:0] sh_, input logic oe_, input logic [7:0] din_,
                                input logic [7:0] ed, input logic ez);
        vec_t v;
        v.name = nm; v.ie = ie_; v.we = we_; v.wa = wa_; v.rae = rae_; v.raa = raa_;
        v.rbe = rbe_; v.rba = rba_; v.alu = alu_; v.sh = sh_; v.oe = oe_; v.din = din_;
        v.e_dout = ed; v.e_z = ez;
        return v;
    endfunction

    // Load a register from din; output gated off so dout must be 0.
    function automatic vec_t ld(input string nm, input logic [1:0] wa_, input logic [7:0] d);
        return mk(nm, 1'b1, 1'b1, wa_, 1'b0, 2'd0, 1'b0, 2'd0, 3'b000, 2'b00, 1'b0, d,
                  8'h00, (d == 8'h00));
    endfunction

    task automatic check_pop();
        exp_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_empty: no expected entry queued");
            return;
        end
        e = exp_q.pop_front();
        n_checks++;
        if (dout !== e.dout || nez !== e.z) begin
            n_fail++;
            $display("FAIL %s: dout=%h nEqZero=%b, required dout=%h nEqZero=%b",
                     e.name, dout, nez, e.dout, e.z);
        end
    endtask

    // Apply a control word (optionally at the next falling edge) and check it.
    task automatic drive(input vec_t v, input bit at_edge);
        exp_t e;
        if (at_edge) @(negedge clk);
        ie = v.ie; we = v.we; wa = v.wa; rae = v.rae; raa = v.raa; rbe = v.rbe;
        rba = v.rba; alu = v.alu; sh = v.sh; oe = v.oe; din = v.din;
        e.name = v.name; e.dout = v.e_dout; e.z = v.e_z;
        exp_q.push_back(e);
        #1;
        check_pop();
    endtask

    task automatic run_sum(input logic [7:0] n, input logic [7:0] exp_sum);
        logic [7:0] r0, r1;
        int budget;
        r0 = 8'h00;
        r1 = n;
        drive(mk("sum_S0", 1'b0, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 3'b000, 2'b00, 1'b0,
                 8'h00, 8'h00, 1'b1), 1'b1);
        drive(ld("sum_S1", 2'd1, n), 1'b1);
        budget = 64;
        while (nez !== 1'b1 && budget > 0) begin
            r0 = r0 + r1;
            drive(mk("sum_S2", 1'b0, 1'b1, 2'd0, 1'b1, 2'd0, 1'b1, 2'd1, 3'b100, 2'b00, 1'b0,
                     8'h00, 8'h00, (r0 == 8'h00)), 1'b1);
            r1 = r1 - 8'h01;
            drive(mk("sum_S3", 1'b0, 1'b1, 2'd1, 1'b1, 2'd1, 1'b0, 2'd0, 3'b111, 2'b00, 1'b0,
                     8'h00, 8'h00, (r1 == 8'h00)), 1'b1);
            budget--;
        end
        if (budget == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sum_timeout: nEqZero never rose for n=%0d", n);
        end
        drive(mk("sum_S4", 1'b0, 1'b0, 2'd0, 1'b1, 2'd0, 1'b0, 2'd0, 3'b000, 2'b00, 1'b1,
                 8'h00, exp_sum, (exp_sum == 8'h00)), 1'b1);
    endtask

    logic [7:0] alu_exp [0:7];
    logic [7:0] sh_exp  [0:3];

    initial begin
        alu_exp = '{8'hA5, 8'h24, 8'hBD, 8'h5A, 8'hE1, 8'h69, 8'hA6, 8'hA4};
        sh_exp  = '{8'h81, 8'h02, 8'h40, 8'hC0};

        vecs.push_back(ld("ld_r0", 2'd0, 8'hA5));
        vecs.push_back(ld("ld_r1", 2'd1, 8'h3C));
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk($sformatf("alu_%0d", i), 1'b0, 1'b0, 2'd0, 1'b1, 2'd0, 1'b1, 2'd1,
                              3'(i), 2'b00, 1'b1, 8'h00, alu_exp[i], 1'b0));
        vecs.push_back(mk("rae_off", 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd1, 3'b000, 2'b00,
                          1'b1, 8'h00, 8'h00, 1'b1));
        vecs.push_back(mk("rbe_off_add", 1'b0, 1'b0, 2'd0, 1'b1, 2'd0, 1'b0, 2'd1, 3'b100, 2'b00,
                          1'b1, 8'h00, 8'hA5, 1'b0));
        vecs.push_back(ld("ld_r3_81", 2'd3, 8'h81));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk($sformatf("sh_%0d", i), 1'b0, 1'b0, 2'd0, 1'b1, 2'd3, 1'b0, 2'd0,
                              3'b000, 2'(i), 1'b1, 8'h00, sh_exp[i], 1'b0));
        vecs.push_back(ld("ld_r3_ff", 2'd3, 8'hFF));
        vecs.push_back(mk("wrap_inc", 1'b0, 1'b0, 2'd0, 1'b1, 2'd3, 1'b0, 2'd0, 3'b110, 2'b00,
                          1'b1, 8'h00, 8'h00, 1'b1));
        vecs.push_back(mk("oe_off", 1'b0, 1'b0, 2'd0, 1'b1, 2'd3, 1'b0, 2'd0, 3'b000, 2'b00,
                          1'b0, 8'h00, 8'h00, 1'b0));
        vecs.push_back(ld("ld_r2_11", 2'd2, 8'h11));
        vecs.push_back(mk("rdw_old", 1'b1, 1'b1, 2'd2, 1'b1, 2'd2, 1'b0, 2'd0, 3'b000, 2'b00,
                          1'b1, 8'h77, 8'h11, 1'b0));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk($sformatf("rdw_hold_%0d", i), 1'b1, 1'b0, 2'd2, 1'b1, 2'd2, 1'b0,
                              2'd0, 3'b000, 2'b00, 1'b1, 8'(8'h30 + i), 8'h77, 1'b0));
        vecs.push_back(mk("same_addr_and", 1'b0, 1'b0, 2'd0, 1'b1, 2'd2, 1'b1, 2'd2, 3'b001,
                          2'b00, 1'b1, 8'h00, 8'h77, 1'b0));
        vecs.push_back(mk("same_addr_sub", 1'b0, 1'b0, 2'd0, 1'b1, 2'd2, 1'b1, 2'd2, 3'b101,
                          2'b00, 1'b1, 8'h00, 8'h00, 1'b1));

        // Power-on reset state.
        rst_n = 1'b0;
        ie = 1'b0; we = 1'b0; wa = 2'd0; rae = 1'b0; raa = 2'd0; rbe = 1'b0; rba = 2'd0;
        alu = 3'b000; sh = 2'b00; oe = 1'b0; din = 8'h00;
        #3;
        drive(mk("por_idle", 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 3'b000, 2'b00, 1'b0,
                 8'h00, 8'h00, 1'b1), 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[k]) drive(vecs[k], 1'b1);

        // Asynchronous reset mid-cycle with non-zero contents.
        @(negedge clk);
        #2 rst_n = 1'b0;
        for (int i = 0; i < 4; i++)
            drive(mk($sformatf("rst_rf%0d", i), 1'b0, 1'b0, 2'd0, 1'b1, 2'(i), 1'b0, 2'd0,
                     3'b000, 2'b00, 1'b1, 8'h00, 8'h00, 1'b1), 1'b0);
        drive(mk("rst_idle", 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 3'b000, 2'b00, 1'b0,
                 8'h00, 8'h00, 1'b1), 1'b0);
        drive(ld("rst_wr_try", 2'd0, 8'h55), 1'b0);
        @(posedge clk);
        drive(mk("rst_wr_blocked", 1'b0, 1'b0, 2'd0, 1'b1, 2'd0, 1'b0, 2'd0, 3'b000, 2'b00,
                 1'b1, 8'h00, 8'h00, 1'b1), 1'b1);
        rst_n = 1'b1;

        run_sum(8'd5, 8'h0F);
        run_sum(8'd0, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gdp_datapath.md
# gdp_datapath

Datapath for the general-purpose datapath (GDP) design. It executes the control word that the GDP control unit issues every clock: input mux, 4-entry register file, ALU, shifter and output buffer. It returns the `nEqZero` status flag, and the control unit's next-state logic consumes that flag in the same cycle. The control unit plus this block form the complete GDP, for example the summation algorithm `sum = n + (n-1) + ... + 1`.

## Interface
- `WIDTH`, default 8: data width of the register file, ALU, shifter, `din` and `dout`.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `IE` input 1: input enable; the mux selects `din` when 1, otherwise the shifter output.
- `WE` input 1: register-file write enable.
- `WA` input 2: register-file write address.
- `RAE` input 1: read port A enable; A = 0 when 0.
- `RAA` input 2: read port A address.
- `RBE` input 1: read port B enable; B = 0 when 0.
- `RBA` input 2: read port B address.
- `ALU` input 3: ALU operation select.
- `SH` input 2: shifter operation select.
- `OE` input 1: output enable.
- `din` input WIDTH: external data input.
- `nEqZero` output 1: high when the mux output equals zero.
- `dout` output WIDTH: shifter output when OE = 1, otherwise all zeros.

## Operation
- Storage: `rf[0..3]`, each WIDTH bits. This is the only sequential state.
- Mux: `mux = IE ? din : sh_out`.
- Write: on a rising clk edge with WE = 1, `rf[WA] <= mux`. With WE = 0, rf holds.
- Reads are combinational:
  - `A = RAE ? rf[RAA] : 0`
  - `B = RBE ? rf[RBA] : 0`
- ALU encoding (all arithmetic modulo 2^WIDTH; no carry or overflow output):
  - 000 pass A
  - 001 A AND B
  - 010 A OR B
  - 011 NOT A
  - 100 A + B
  - 101 A − B
  - 110 A + 1
  - 111 A − 1
- Shifter encoding, applied to the ALU result:
  - 00 pass
  - 01 shift left 1, LSB filled with 0
  - 10 shift right 1, MSB filled with 0
  - 11 rotate right 1
- `nEqZero = (mux == 0)`. It is combinational, so it reflects the value being written in the current cycle. The control unit's branches (n == 0 at the load step and at the decrement step) depend on this.
- `dout = OE ? sh_out : 0`. It is combinational, with no holding register.
- Unused or illegal encodings: none; every 3-bit ALU code and every 2-bit SH code is defined above.

## Timing
- Reset:
  - Assertion of `rst_n` = 0 clears all four rf entries immediately, with no dependence on clk. The clear holds while rst_n is low, and writes are ignored.
  - With rf = 0, IE = 0 and OE = 0: `dout` = 0 and `nEqZero` = 1.
- Deassertion: the first write can occur on the first rising edge after rst_n goes high.
- Reset mid-operation: rf contents are lost (cleared to 0). The control unit is responsible for restarting the sequence.
- Latency:
  - Control word to `nEqZero` and `dout`: combinational, same cycle.
  - A written value is visible on the read ports the cycle after the write edge.
- Read-during-write, same address in the same cycle: the read returns the old (pre-edge) value. There is no write-through bypass.
- Same-cycle read of A and B at the same address: legal; both ports return the same value.
- Combinational loop: none. The mux → rf path is broken by the register, and IE = 1 breaks the feedback path to `nEqZero`.

## Test plan
- Reset: drive rst_n = 0 mid-clock after loading rf with non-zero values. Required: all rf entries read as 0 immediately, `dout` = 0 with OE = 0, `nEqZero` = 1.
- Summation n = 5:
  - Drive the control-unit sequence: S0 (clear R0), S1 (load din = 5 into R1), then S2/S3 pairs until `nEqZero` = 1, then S4.
  - Required: `nEqZero` = 0 through the loop, going to 1 when R1 reaches 0.
  - Required: `dout` = 15 (0x0F) in S4.
- Summation n = 0: din = 0 in S1. Required: `nEqZero` = 1 in that same cycle; after the write, `dout` = 0 in S4.
- ALU sweep: rf[0] = 0xA5, rf[1] = 0x3C, SH = 00, OE = 1, ALU 000..111. Required `dout` in order: 0xA5, 0x24, 0xBD, 0x5A, 0xE1, 0x69, 0xA6, 0xA4.
- Shifter and wrap: A = 0x81, ALU = 000, SH 00..11. Required `dout`: 0x81, 0x02, 0x40, 0xC0. With A = 0xFF and ALU = 110, required `dout` = 0x00 and `nEqZero` = 1.
- Read-during-write: write 0x77 to R2 while reading R2 on port A (RAE = 1). Required: A shows the old value that cycle and 0x77 the next cycle. With WE = 0, required: R2 unchanged across 3 clocks.
